cu_if_fetch: RTL and testbench

Instruction-fetch stage of the multi-cycle control unit. It sits directly upstream of the decode stage. It owns the program counter, fetches one 32-bit word per request over a req/ack instruction-memory handshake, and drives Cu_IR, which the decode stage consumes. It accepts next-PC updates from CU_top and reports misalignment and bus-timeout faults.

---
 rtl/cu_pkg.sv | 7 +
 rtl/cu_if_timeout.sv | 28 ++
 rtl/cu_if_fetch.sv | 137 +++++++++++++
 tb/tb_cu_if_fetch.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared types and constants for the control-unit instruction-fetch stage.
package cu_pkg;
  typedef enum logic [1:0] {IDLE, REQ, FAULT} if_state_t;

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [1:0]  PC_ALIGN_MASK = 2'b11;
endpackage

// File: rtl/cu_if_timeout.sv
// Request-wait counter: counts cycles spent waiting for imem_ack and flags
// the cycle in which the wait budget is used up.
module cu_if_timeout #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic expired
);
  localparam logic [7:0] LAST = 8'(LIMIT - 1);

  logic [7:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
    end else if (clear) begin
      cnt_q <= 8'd0;
    end else if (en) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // High during the LIMIT-th waiting cycle; the edge closing it would be one too many.
  assign expired = en && (cnt_q == LAST);
endmodule

// File: rtl/cu_if_fetch.sv
// Instruction-fetch stage: owns the PC, fetches one word per fetch_start over
// a req/ack memory handshake and latches it into Cu_IR for decode.
module cu_if_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = cu_pkg::NOP_INSTR
) (
  input  logic        soc_clk,
  input  logic        IF_reset_n,
  input  logic        fetch_start,
  input  logic        pc_update_valid,
  input  logic [31:0] pc_next,
  input  logic        fault_clear,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] Cu_IR,
  output logic [31:0] pc_out,
  output logic        ir_valid,
  output logic        fetch_busy,
  output logic        fault_misaligned,
  output logic        fault_timeout
);
  import cu_pkg::*;

  // Handshake: imem_req is high for the whole REQ state with imem_addr held
  // at the PC; the access completes on the first rising edge where imem_ack
  // is high while imem_req is high. ack outside a request is ignored.

  if_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d, pc_eff;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] ir_q, ir_d;
  logic        ir_valid_q, ir_valid_d;
  logic        mis_q, mis_d;
  logic        to_q, to_d;
  logic        expired;

  cu_if_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk    (soc_clk),
    .rst_n  (IF_reset_n),
    .clear  ((state_q != REQ) || imem_ack),
    .en     (state_q == REQ),
    .expired(expired)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    ir_d         = ir_q;
    ir_valid_d   = 1'b0;
    mis_d        = mis_q;
    to_d         = to_q;
    // A same-cycle update takes effect before the alignment check.
    pc_eff       = pc_update_valid ? pc_next : pc_q;
    case (state_q)
      IDLE: begin
        pc_d = pc_eff;
        if (fetch_start) begin
          if ((pc_eff[1:0] & PC_ALIGN_MASK) != 2'b00) begin
            state_d = FAULT;
            mis_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (pc_update_valid) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = pc_next;
        end
        if (imem_ack) begin
          ir_d       = imem_rdata;
          ir_valid_d = 1'b1;
          state_d    = IDLE;
        end else if (expired) begin
          state_d = FAULT;
          to_d    = 1'b1;
        end
        // Deferred PC update lands on the leaving edge so imem_addr stays put.
        if (state_d != REQ) begin
          if (pc_update_valid) begin
            pc_d = pc_next;
          end else if (pend_valid_q) begin
            pc_d = pend_pc_q;
          end
          pend_valid_d = 1'b0;
        end
      end
      FAULT: begin
        pc_d = pc_eff;
        if (fault_clear) begin
          state_d = IDLE;
          mis_d   = 1'b0;
          to_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge soc_clk or negedge IF_reset_n) begin
    if (!IF_reset_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pend_pc_q    <= 32'h0;
      pend_valid_q <= 1'b0;
      ir_q         <= NOP_INSTR;
      ir_valid_q   <= 1'b0;
      mis_q        <= 1'b0;
      to_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      ir_q         <= ir_d;
      ir_valid_q   <= ir_valid_d;
      mis_q        <= mis_d;
      to_q         <= to_d;
    end
  end

  assign imem_req         = (state_q == REQ);
  assign fetch_busy       = (state_q == REQ);
  assign imem_addr        = pc_q;
  assign pc_out           = pc_q;
  assign Cu_IR            = ir_q;
  assign ir_valid         = ir_valid_q;
  assign fault_misaligned = mis_q;
  assign fault_timeout    = to_q;
endmodule

// File: tb/tb_cu_if_fetch.sv
// Directed bench for cu_if_fetch: a cycle table for the basic fetch/fault flow
// plus hand-written timeout, late-update and mid-fetch reset sequences.
module tb_cu_if_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        soc_clk;
  logic        IF_reset_n;
  logic        fetch_start;
  logic        pc_update_valid;
  logic [31:0] pc_next;
  logic        fault_clear;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] Cu_IR;
  logic [31:0] pc_out;
  logic        ir_valid;
  logic        fetch_busy;
  logic        fault_misaligned;
  logic        fault_timeout;

  int total = 0;
  int bad   = 0;

  cu_if_fetch #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(16),
    .NOP_INSTR     (NOP)
  ) dut (
    .soc_clk         (soc_clk),
    .IF_reset_n      (IF_reset_n),
    .fetch_start     (fetch_start),
    .pc_update_valid (pc_update_valid),
    .pc_next         (pc_next),
    .fault_clear     (fault_clear),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ack        (imem_ack),
    .Cu_IR           (Cu_IR),
    .pc_out          (pc_out),
    .ir_valid        (ir_valid),
    .fetch_busy      (fetch_busy),
    .fault_misaligned(fault_misaligned),
    .fault_timeout   (fault_timeout)
  );

  // clock / reset
  initial soc_clk = 1'b0;
  always #5 soc_clk = ~soc_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        fs;
    logic        pu;
    logic [31:0] pn;
    logic        fc;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic        e_irv;
    logic        e_mis;
    logic        e_to;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    fetch_start     = 1'b0;
    pc_update_valid = 1'b0;
    pc_next         = 32'h0;
    fault_clear     = 1'b0;
    imem_ack        = 1'b0;
    imem_rdata      = 32'h0;
  endtask

  task automatic chk_row(input int i, input vec_t v);
    string s;
    s = $sformatf("row%0d", i);
    chk({s, ".imem_req"}, {31'h0, imem_req}, {31'h0, v.e_req});
    chk({s, ".fetch_busy"}, {31'h0, fetch_busy}, {31'h0, v.e_req});
    chk({s, ".pc_out"}, pc_out, v.e_pc);
    chk({s, ".imem_addr"}, imem_addr, v.e_pc);
    chk({s, ".Cu_IR"}, Cu_IR, v.e_ir);
    chk({s, ".ir_valid"}, {31'h0, ir_valid}, {31'h0, v.e_irv});
    chk({s, ".fault_mis"}, {31'h0, fault_misaligned}, {31'h0, v.e_mis});
    chk({s, ".fault_to"}, {31'h0, fault_timeout}, {31'h0, v.e_to});
  endtask

  // withheld ack: request lasts exactly 16 cycles, then timeout fault
  task automatic seq_timeout();
    int n;
    @(negedge soc_clk);
    drive_idle();
    pc_update_valid = 1'b1;
    pc_next         = 32'h0000_0040;
    @(negedge soc_clk);
    drive_idle();
    fetch_start = 1'b1;
    @(negedge soc_clk);
    drive_idle();
    n = 0;
    while (imem_req && n < 40) begin
      n++;
      chk("to.addr_stable", imem_addr, 32'h0000_0040);
      @(negedge soc_clk);
    end
    chk("to.req_cycles", n, 16);
    chk("to.fault_timeout", {31'h0, fault_timeout}, 32'h1);
    chk("to.busy_low", {31'h0, fetch_busy}, 32'h0);
    chk("to.ir_held", Cu_IR, 32'hCAFE_F00D);
    fault_clear = 1'b1;
    @(negedge soc_clk);
    drive_idle();
    chk("to.cleared", {31'h0, fault_timeout}, 32'h0);
  endtask

  // ack on the 16th edge wins over the timeout
  task automatic seq_ack_at_limit();
    @(negedge soc_clk);
    drive_idle();
    fetch_start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge soc_clk);
      drive_idle();
      chk($sformatf("lim.req_c%0d", k), {31'h0, imem_req}, 32'h1);
      if (k == 16) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'h0BAD_C0DE;
      end
    end
    @(negedge soc_clk);
    drive_idle();
    chk("lim.no_fault", {31'h0, fault_timeout}, 32'h0);
    chk("lim.ir", Cu_IR, 32'h0BAD_C0DE);
    chk("lim.irv", {31'h0, ir_valid}, 32'h1);
    chk("lim.req_low", {31'h0, imem_req}, 32'h0);
  endtask

  // ack delayed 5 cycles, PC update in REQ cycle 2 deferred to the ack edge
  task automatic seq_late_update();
    @(negedge soc_clk);
    drive_idle();
    fetch_start = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge soc_clk);
      drive_idle();
      chk($sformatf("upd.req_c%0d", k), {31'h0, imem_req}, 32'h1);
      chk($sformatf("upd.addr_c%0d", k), imem_addr, 32'h0000_0040);
      if (k == 2) begin
        pc_update_valid = 1'b1;
        pc_next         = 32'h0000_0200;
      end
      if (k == 6) begin
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A0_0093;
      end
    end
    @(negedge soc_clk);
    drive_idle();
    chk("upd.pc", pc_out, 32'h0000_0200);
    chk("upd.ir", Cu_IR, 32'h00A0_0093);
    chk("upd.irv", {31'h0, ir_valid}, 32'h1);
  endtask

  // asynchronous reset in REQ cycle 3, then a stray ack after release
  task automatic seq_reset_mid_fetch();
    @(negedge soc_clk);
    drive_idle();
    fetch_start = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge soc_clk);
      drive_idle();
      chk($sformatf("rst.req_c%0d", k), {31'h0, imem_req}, 32'h1);
    end
    #2;
    IF_reset_n = 1'b0;
    #1;
    chk("rst.req_now", {31'h0, imem_req}, 32'h0);
    chk("rst.ir_nop", Cu_IR, NOP);
    chk("rst.pc", pc_out, 32'h0);
    chk("rst.busy", {31'h0, fetch_busy}, 32'h0);
    @(negedge soc_clk);
    IF_reset_n = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge soc_clk);
      chk($sformatf("rst.late_req%0d", k), {31'h0, imem_req}, 32'h0);
      chk($sformatf("rst.late_ir%0d", k), Cu_IR, NOP);
      chk($sformatf("rst.late_irv%0d", k), {31'h0, ir_valid}, 32'h0);
    end
    drive_idle();
  endtask

  initial begin
    //            fs  pu  pn            fc  ack rd              req pc            ir            irv mis to
    tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        NOP,          1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'h0020_8133, 1'b1, 32'h0,       NOP,          1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0020_8133, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 32'h100,      1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        32'h0020_8133, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1, 32'h100,     32'h0020_8133, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'h102,      1'b0, 1'b0, 32'h0,        1'b0, 32'h100,      32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h102,      32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h102,      32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 32'h1111_1111, 1'b0, 32'h102,     32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'h104,      1'b1, 1'b0, 32'h0,        1'b0, 32'h102,      32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h104,      32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h104,      32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b1, 32'h104,      32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h104,    32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'hFFFF_FFFC, 32'h1234_5678, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 32'hCAFE_F00D, 1'b1, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'hFFFF_FFFC, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0};

    IF_reset_n = 1'b0;
    drive_idle();
    repeat (2) @(negedge soc_clk);
    chk("reset.imem_req", {31'h0, imem_req}, 32'h0);
    chk("reset.busy", {31'h0, fetch_busy}, 32'h0);
    chk("reset.pc", pc_out, 32'h0);
    chk("reset.ir", Cu_IR, NOP);
    chk("reset.irv", {31'h0, ir_valid}, 32'h0);
    chk("reset.mis", {31'h0, fault_misaligned}, 32'h0);
    chk("reset.to", {31'h0, fault_timeout}, 32'h0);
    IF_reset_n = 1'b1;

    // each row: check outputs for this cycle, then drive inputs for its closing edge
    for (int i = 0; i < 17; i++) begin
      @(negedge soc_clk);
      chk_row(i, tbl[i]);
      fetch_start     = tbl[i].fs;
      pc_update_valid = tbl[i].pu;
      pc_next         = tbl[i].pn;
      fault_clear     = tbl[i].fc;
      imem_ack        = tbl[i].ack;
      imem_rdata      = tbl[i].rd;
    end

    seq_timeout();
    seq_ack_at_limit();
    seq_late_update();
    seq_reset_mid_fetch();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
